// File: rtl/ahb_slave_sram_port_if.sv
// ---------------------------------------------------------------------------
// ahb_slave_sram_port_if
//
// Purpose: bundles the AHB-Lite slave-side signals that the interconnect
// forwards to one memory endpoint, together with the response signals the
// endpoint returns.
//
// Signals:
//   hselx      slave select
//   haddr      transfer address (ADDR_WIDTH)
//   htrans     0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
//   hwrite     1 = write
//   hsize      transfer size
//   hburst     burst type (carried, not interpreted)
//   hprot      protection (carried, not interpreted)
//   hmastlock  locked transfer (carried, not interpreted)
//   hwdata     write data (data phase)
//   hreadyout  slave ready / data phase complete
//   hrdata     read data
//   hresp      0 OKAY, 1 ERROR
//
// Modports:
//   master  drives the request side, observes the response
//   slave   observes the request side, drives the response
// ---------------------------------------------------------------------------
interface ahb_slave_sram_port_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  hselx;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic [3:0]            hprot;
    logic                  hmastlock;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  hreadyout;
    logic [DATA_WIDTH-1:0] hrdata;
    logic                  hresp;

    modport master (
        output hselx, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata,
        input  hreadyout, hrdata, hresp
    );

    modport slave (
        input  hselx, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata,
        output hreadyout, hrdata, hresp
    );
endinterface

// File: rtl/ahb_slave_sram_port.sv
// ---------------------------------------------------------------------------
// ahb_slave_sram_port
//
// Purpose: AHB-Lite slave memory endpoint. Holds a word-organised RAM,
// inserts WAIT_STATES wait cycles on every legal transfer and produces the
// two-cycle ERROR response for illegal ones.
//
// Ports:
//   hclk      clock, rising edge
//   hresetn   synchronous active-low reset
//   bus       ahb_slave_sram_port_if.slave (request in, hreadyout/hrdata/hresp out)
//
// Parameters:
//   ADDR_WIDTH   address width (must exceed log2(MEM_DEPTH)+2)
//   DATA_WIDTH   data width, only 32 supported
//   MEM_DEPTH    number of 32-bit words, power of two
//   WAIT_STATES  wait cycles per legal transfer, 0..7
//
// Build option:
//   AHB_SRAM_RANGE_CHECK_EN  when defined, addresses beyond the RAM take the
//                            ERROR path; otherwise the word index wraps.
// ---------------------------------------------------------------------------
module ahb_slave_sram_port #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    ahb_slave_sram_port_if.slave bus
);

    localparam int         IDX_W = $clog2(MEM_DEPTH);
    localparam logic [2:0] WS    = 3'(WAIT_STATES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUSY,
        ST_LAST,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t     state;
    logic [2:0] wait_cnt;
    logic       hreadyout_q;
    logic       hresp_q;

    // Address-phase attributes of the transfer currently in its data phase
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       lo_q;
    logic [2:0]       size_q;
    logic             write_q;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic accept;
    logic legal;
    logic out_of_range;

    function automatic logic is_legal(input logic [2:0] size,
                                      input logic [1:0] lo,
                                      input logic       oor);
        logic bad;
        bad = (size > 3'd2)
            | ((size == 3'd1) & lo[0])
            | ((size == 3'd2) & (lo != 2'b00))
            | oor;
        return !bad;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] size,
                                             input logic [1:0] lo);
        logic [3:0] m;
        case (size)
            3'd0:    m = 4'b0001 << lo;
            3'd1:    m = lo[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

`ifdef AHB_SRAM_RANGE_CHECK_EN
    assign out_of_range = |bus.haddr[ADDR_WIDTH-1:IDX_W+2];
`else
    assign out_of_range = 1'b0;
`endif

    // hburst/hprot/hmastlock are not interpreted; upper address bits only
    // matter when the range check is built in.
    logic unused_ok;
    assign unused_ok = ^{bus.hburst, bus.hprot, bus.hmastlock,
                         bus.haddr[ADDR_WIDTH-1:IDX_W+2]};

    // Only NONSEQ/SEQ (htrans[1]=1) are captured, and only while ready
    assign accept = hreadyout_q & bus.hselx & bus.htrans[1];
    assign legal  = is_legal(bus.hsize, bus.haddr[1:0], out_of_range);

    // Control FSM; hreadyout/hresp are registered alongside the state so
    // they never depend combinationally on the request inputs.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state       <= ST_IDLE;
            wait_cnt    <= 3'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            case (state)
                ST_BUSY: begin
                    wait_cnt <= wait_cnt - 3'd1;
                    if (wait_cnt == 3'd1) begin
                        state       <= ST_LAST;
                        hreadyout_q <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    state       <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b1;
                end
                default: begin
                    // IDLE, LAST and ERR2 all accept the next address phase
                    if (accept) begin
                        if (!legal) begin
                            state       <= ST_ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= 1'b1;
                        end else if (WS == 3'd0) begin
                            state       <= ST_LAST;
                            hreadyout_q <= 1'b1;
                            hresp_q     <= 1'b0;
                        end else begin
                            state       <= ST_BUSY;
                            wait_cnt    <= WS;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= 1'b0;
                        end
                    end else begin
                        state       <= ST_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Address-phase capture (datapath, no reset needed: only consumed in LAST)
    always_ff @(posedge hclk) begin
        if (accept) begin
            idx_q   <= bus.haddr[IDX_W+1:2];
            lo_q    <= bus.haddr[1:0];
            size_q  <= bus.hsize;
            write_q <= bus.hwrite;
        end
    end

    // RAM write on the edge that ends LAST; a reset on that edge drops it
    always_ff @(posedge hclk) begin
        if (hresetn && (state == ST_LAST) && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_mask(size_q, lo_q)[b]) begin
                    mem[idx_q][8*b +: 8] <= bus.hwdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.hreadyout = hreadyout_q;
    assign bus.hresp     = hresp_q;
    assign bus.hrdata    = ((state == ST_LAST) && !write_q) ? mem[idx_q] : '0;

endmodule

// File: tb/tb_ahb_slave_sram_port.sv
module tb_ahb_slave_sram_port;

    localparam int DEPTH = 1024;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic [1:0]  sel;
    logic        hselx;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;

    int checks   = 0;
    int failures = 0;

    always #5 hclk = ~hclk;

    ahb_slave_sram_port_if bus0 ();
    ahb_slave_sram_port_if bus1 ();
    ahb_slave_sram_port_if bus2 ();

    assign bus0.hselx = hselx && (sel == 2'd0);
    assign bus1.hselx = hselx && (sel == 2'd1);
    assign bus2.hselx = hselx && (sel == 2'd2);
    assign bus0.haddr = haddr;  assign bus1.haddr = haddr;  assign bus2.haddr = haddr;
    assign bus0.htrans = htrans; assign bus1.htrans = htrans; assign bus2.htrans = htrans;
    assign bus0.hwrite = hwrite; assign bus1.hwrite = hwrite; assign bus2.hwrite = hwrite;
    assign bus0.hsize = hsize;  assign bus1.hsize = hsize;  assign bus2.hsize = hsize;
    assign bus0.hwdata = hwdata; assign bus1.hwdata = hwdata; assign bus2.hwdata = hwdata;
    assign bus0.hburst = 3'd0;  assign bus1.hburst = 3'd1;  assign bus2.hburst = 3'd0;
    assign bus0.hprot = 4'h3;   assign bus1.hprot = 4'h3;   assign bus2.hprot = 4'h3;
    assign bus0.hmastlock = 1'b0; assign bus1.hmastlock = 1'b0; assign bus2.hmastlock = 1'b0;

    ahb_slave_sram_port #(.MEM_DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (.hclk(hclk), .hresetn(hresetn), .bus(bus0));
    ahb_slave_sram_port #(.MEM_DEPTH(DEPTH), .WAIT_STATES(1)) dut1 (.hclk(hclk), .hresetn(hresetn), .bus(bus1));
    ahb_slave_sram_port #(.MEM_DEPTH(DEPTH), .WAIT_STATES(3)) dut2 (.hclk(hclk), .hresetn(hresetn), .bus(bus2));

    logic        rdy, resp;
    logic [31:0] rdata;
    assign rdy   = (sel == 2'd0) ? bus0.hreadyout : (sel == 2'd1) ? bus1.hreadyout : bus2.hreadyout;
    assign resp  = (sel == 2'd0) ? bus0.hresp     : (sel == 2'd1) ? bus1.hresp     : bus2.hresp;
    assign rdata = (sel == 2'd0) ? bus0.hrdata    : (sel == 2'd1) ? bus1.hrdata    : bus2.hrdata;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        wr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        tbl [20];
    int          ntbl = 0;
    logic [31:0] mdl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] a, input logic [2:0] s, input logic w,
                           input logic [31:0] d, input logic er, input logic [31:0] rd);
        tbl[ntbl].addr      = a;
        tbl[ntbl].size      = s;
        tbl[ntbl].wr        = w;
        tbl[ntbl].wdata     = d;
        tbl[ntbl].exp_err   = er;
        tbl[ntbl].exp_rdata = rd;
        ntbl++;
    endtask

    // One isolated transfer: address phase, then wait for completion.
    task automatic do_xfer(input logic [31:0] a, input logic [2:0] s, input logic w, input logic [31:0] d,
                           output logic r_first, output logic r_last, output logic [31:0] rd,
                           output int waits, output logic timed_out);
        @(negedge hclk);
        hselx = 1'b1; htrans = 2'b10; haddr = a; hsize = s; hwrite = w;
        @(posedge hclk); #1;
        hselx = 1'b0; htrans = 2'b00; hwdata = d;
        waits = 0; timed_out = 1'b1; r_first = 1'b0; r_last = 1'b0; rd = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge hclk);
            if (c == 0) r_first = resp;
            if (rdy) begin
                r_last = resp; rd = rdata; timed_out = 1'b0;
                break;
            end
            waits++;
        end
        @(posedge hclk); #1;
    endtask

    task automatic check_xfer(input string tag, input logic [31:0] a, input logic [2:0] s, input logic w,
                              input logic [31:0] d, input logic exp_err, input logic [31:0] exp_rd,
                              input int exp_waits);
        logic rf, rl, to;
        logic [31:0] rd;
        int wt;
        do_xfer(a, s, w, d, rf, rl, rd, wt, to);
        chk({tag, " timeout"}, 32'(to), 32'd0);
        chk({tag, " resp_first"}, 32'(rf), 32'(exp_err));
        chk({tag, " resp_last"}, 32'(rl), 32'(exp_err));
        chk({tag, " hrdata"}, rd, exp_rd);
        chk({tag, " waits"}, 32'(wt), 32'(exp_waits));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic oor_err;
        logic [31:0] oor_rd;
        hresetn = 1'b0; sel = 2'd1; hselx = 1'b0; haddr = '0; htrans = 2'b00;
        hwrite = 1'b0; hsize = 3'd0; hwdata = '0;

        // Reset state of all three instances
        repeat (2) @(posedge hclk);
        #1;
        chk("reset rdy0", 32'(bus0.hreadyout), 32'd1);
        chk("reset rdy1", 32'(bus1.hreadyout), 32'd1);
        chk("reset rdy2", 32'(bus2.hreadyout), 32'd1);
        chk("reset resp0", 32'(bus0.hresp), 32'd0);
        chk("reset resp1", 32'(bus1.hresp), 32'd0);
        chk("reset resp2", 32'(bus2.hresp), 32'd0);
        chk("reset rdata0", bus0.hrdata, 32'd0);
        chk("reset rdata1", bus1.hrdata, 32'd0);
        chk("reset rdata2", bus2.hrdata, 32'd0);
        @(negedge hclk);
        hresetn = 1'b1;

        // Directed vectors on the WAIT_STATES=1 instance
`ifdef AHB_SRAM_RANGE_CHECK_EN
        oor_err = 1'b1; oor_rd = 32'h0102_0304;
`else
        oor_err = 1'b0; oor_rd = 32'hCAFE_F00D;
`endif
        add_vec(32'h10, 3'd2, 1, 32'hDEAD_BEEF, 0, 32'h0);
        add_vec(32'h10, 3'd2, 0, 32'h0,         0, 32'hDEAD_BEEF);
        add_vec(32'h20, 3'd2, 1, 32'h1122_3344, 0, 32'h0);
        add_vec(32'h22, 3'd0, 1, 32'h00AA_0000, 0, 32'h0);
        add_vec(32'h20, 3'd2, 0, 32'h0,         0, 32'h11AA_3344);
        add_vec(32'h20, 3'd2, 1, 32'h1122_3344, 0, 32'h0);
        add_vec(32'h21, 3'd2, 0, 32'h0,         1, 32'h0);
        add_vec(32'h20, 3'd2, 0, 32'h0,         0, 32'h1122_3344);
        add_vec(32'h12, 3'd1, 1, 32'hBEEF_0000, 0, 32'h0);
        add_vec(32'h10, 3'd2, 0, 32'h0,         0, 32'hBEEF_BEEF);
        add_vec(32'h11, 3'd1, 1, 32'h1234_5678, 1, 32'h0);
        add_vec(32'h10, 3'd3, 0, 32'h0,         1, 32'h0);
        add_vec(32'h13, 3'd0, 1, 32'h7700_0000, 0, 32'h0);
        add_vec(32'h10, 3'd2, 0, 32'h0,         0, 32'h77EF_BEEF);
        add_vec(32'h00, 3'd2, 1, 32'h0102_0304, 0, 32'h0);
        add_vec(32'h1000, 3'd2, 1, 32'hCAFE_F00D, oor_err, 32'h0);
        add_vec(32'h00, 3'd2, 0, 32'h0,         0, oor_rd);
        add_vec(32'h22, 3'd1, 0, 32'h0,         0, 32'h1122_3344);

        sel = 2'd1;
        for (int i = 0; i < ntbl; i++) begin
            check_xfer($sformatf("vec%0d", i), tbl[i].addr, tbl[i].size, tbl[i].wr,
                       tbl[i].wdata, tbl[i].exp_err, tbl[i].exp_rdata, 1);
        end

        // Pipelined NONSEQ/SEQ/SEQ reads, WAIT_STATES=0
        sel = 2'd0;
        check_xfer("pre0", 32'h10, 3'd2, 1, 32'hA1A1_0001, 0, 32'h0, 0);
        check_xfer("pre1", 32'h14, 3'd2, 1, 32'hB2B2_0002, 0, 32'h0, 0);
        check_xfer("pre2", 32'h18, 3'd2, 1, 32'hC3C3_0003, 0, 32'h0, 0);
        @(negedge hclk);
        hselx = 1'b1; htrans = 2'b10; haddr = 32'h10; hsize = 3'd2; hwrite = 1'b0;
        @(posedge hclk); #1;
        htrans = 2'b11; haddr = 32'h14;
        @(negedge hclk);
        chk("pipe rdy1", 32'(rdy), 32'd1);
        chk("pipe data1", rdata, 32'hA1A1_0001);
        @(posedge hclk); #1;
        haddr = 32'h18;
        @(negedge hclk);
        chk("pipe rdy2", 32'(rdy), 32'd1);
        chk("pipe data2", rdata, 32'hB2B2_0002);
        @(posedge hclk); #1;
        hselx = 1'b0; htrans = 2'b00;
        @(negedge hclk);
        chk("pipe rdy3", 32'(rdy), 32'd1);
        chk("pipe data3", rdata, 32'hC3C3_0003);

        // Read accepted during the LAST cycle of a write sees the new data
        @(negedge hclk);
        hselx = 1'b1; htrans = 2'b10; haddr = 32'h40; hsize = 3'd2; hwrite = 1'b1;
        @(posedge hclk); #1;
        hwdata = 32'h5A5A_1234; hwrite = 1'b0;
        @(negedge hclk);
        chk("raw wr rdy", 32'(rdy), 32'd1);
        chk("raw wr rdata", rdata, 32'h0);
        @(posedge hclk); #1;
        hselx = 1'b0; htrans = 2'b00;
        @(negedge hclk);
        chk("raw rd rdy", 32'(rdy), 32'd1);
        chk("raw rd data", rdata, 32'h5A5A_1234);
        @(posedge hclk); #1;

        // Reset during BUSY of a write, WAIT_STATES=3
        sel = 2'd2;
        check_xfer("rst pre", 32'h30, 3'd2, 1, 32'h0BAD_F00D, 0, 32'h0, 3);
        @(negedge hclk);
        hselx = 1'b1; htrans = 2'b10; haddr = 32'h30; hsize = 3'd2; hwrite = 1'b1;
        @(posedge hclk); #1;
        hselx = 1'b0; htrans = 2'b00; hwdata = 32'hFFFF_FFFF;
        @(negedge hclk);
        chk("rst busy rdy", 32'(rdy), 32'd0);
        hresetn = 1'b0;
        @(posedge hclk); #1;
        hresetn = 1'b1;
        @(negedge hclk);
        chk("rst after rdy", 32'(rdy), 32'd1);
        chk("rst after resp", 32'(resp), 32'd0);
        repeat (4) @(posedge hclk);
        check_xfer("rst post", 32'h30, 3'd2, 0, 32'h0, 0, 32'h0BAD_F00D, 3);

        // Randomized transfers against a byte-level memory model
        for (int k = 0; k < 3; k++) begin
            int ws;
            sel = 2'(k);
            ws  = (k == 0) ? 0 : (k == 1) ? 1 : 3;
            for (int i = 0; i < 16; i++) begin
                logic [31:0] d;
                d = $urandom;
                mdl[i] = d;
                check_xfer($sformatf("init%0d_%0d", k, i), 32'h200 + 32'(4 * i), 3'd2, 1, d, 0, 32'h0, ws);
            end
            for (int n = 0; n < 60; n++) begin
                int unsigned a, widx, lo, nbytes;
                logic [2:0]  s;
                logic        w, ill;
                logic [31:0] d, exp_rd;
                a  = 32'h200 + $urandom_range(0, 63);
                if ($urandom_range(0, 7) == 0) a = a + DEPTH * 4 * $urandom_range(1, 3);
                s  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
                w  = 1'($urandom_range(0, 1));
                d  = $urandom;
                lo = a % 4;
                nbytes = 1 << s;
                ill = (s > 3'd2) || (lo % nbytes != 0);
`ifdef AHB_SRAM_RANGE_CHECK_EN
                if ((a / 4) >= DEPTH) ill = 1'b1;
`endif
                widx   = ((a / 4) % DEPTH) - 128;
                exp_rd = 32'h0;
                if (!ill) begin
                    if (!w) exp_rd = mdl[widx];
                    else begin
                        for (int b = 0; b < 4; b++) begin
                            if (b >= lo && b < lo + nbytes) mdl[widx][8*b +: 8] = d[8*b +: 8];
                        end
                    end
                end
                check_xfer($sformatf("rnd%0d_%0d a=%08h s=%0d w=%0d", k, n, a, s, w),
                           a, s, w, d, ill, exp_rd, ill ? 1 : ws);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
